// File: rtl/huffman_bit_feeder.sv
// Byte-to-bit front end for the Huffman symbol decoder: left-aligned bit buffer, comparator window, symbol output.
// Optional HUFF_SYM_COUNT_EN adds sym_count, a per-stream count of symbol handshakes.
module huffman_bit_feeder #(
  parameter int MAX_CODE = 9,
  parameter int BUF_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [MAX_CODE-1:0] shift_buf,
  output logic [3:0]          bit_count,
  input  logic                match_flag,
  input  logic [3:0]          match_symbol,
  input  logic [3:0]          match_len,
  output logic [3:0]          sym_data,
  output logic                sym_valid,
  input  logic                sym_ready,
  output logic                done,
  output logic                err
`ifdef HUFF_SYM_COUNT_EN
  ,
  output logic [15:0]         sym_count
`endif
);

  localparam int CW = $clog2(BUF_W + 1);
  localparam logic [CW-1:0]       FILL_MAX = CW'(BUF_W - 8);
  localparam logic [CW-1:0]       CODE_MAX = CW'(MAX_CODE);
  localparam logic [CW-1:0]       BYTE_W   = CW'(8);
  localparam logic [MAX_CODE-1:0] WIN_ONES = '1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state, state_n;
  logic [BUF_W-1:0]  bit_buf, buf_n;
  logic [CW-1:0]     count, count_n;
  logic [3:0]        sym_data_n;
  logic              sym_valid_n, done_n, err_n;

  logic [CW-1:0]     len;
  logic [BUF_W-1:0]  byte_word;
  logic              hit, consume, in_hs, stuck, drain_exit;

  assign len        = CW'(match_len);
  assign hit        = match_flag && (match_len != 4'd0) && (len <= count);
  assign consume    = hit && (!sym_valid || sym_ready);
  assign in_ready   = (state == RUN) && (count <= FILL_MAX);
  assign in_hs      = in_valid && in_ready;
  assign stuck      = !hit && (count >= CODE_MAX);
  assign drain_exit = (state == DRAIN) && !hit && (count < CODE_MAX) &&
                      (!sym_valid || sym_ready);
  assign byte_word  = {in_data, {(BUF_W-8){1'b0}}};

  // Bits below count are already zero by construction; the mask keeps the window contract explicit.
  assign shift_buf  = bit_buf[BUF_W-1 -: MAX_CODE] & ~(WIN_ONES >> count);
  assign bit_count  = (count >= CODE_MAX) ? 4'(MAX_CODE) : 4'(count);

  always_comb begin
    state_n     = state;
    buf_n       = bit_buf;
    count_n     = count;
    sym_data_n  = sym_data;
    sym_valid_n = sym_valid;
    done_n      = 1'b0;
    err_n       = err;

    if (sym_ready) sym_valid_n = 1'b0;
    if (consume) begin
      sym_data_n  = match_symbol;
      sym_valid_n = 1'b1;
      buf_n       = bit_buf << len;
      count_n     = count - len;
    end

    if (stuck) begin
      err_n   = 1'b1;
      buf_n   = '0;
      count_n = '0;
      if (state == DRAIN) begin
        done_n  = 1'b1;
        state_n = RUN;
      end
    end else if (drain_exit) begin
      buf_n   = '0;
      count_n = '0;
      done_n  = 1'b1;
      state_n = RUN;
    end

    // Append lands behind whatever survives this cycle's consume/clear.
    if (in_hs) begin
      buf_n   = buf_n | (byte_word >> count_n);
      count_n = count_n + BYTE_W;
      if (in_last) state_n = DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      bit_buf   <= '0;
      count     <= '0;
      sym_data  <= '0;
      sym_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      bit_buf   <= buf_n;
      count     <= count_n;
      sym_data  <= sym_data_n;
      sym_valid <= sym_valid_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

`ifdef HUFF_SYM_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || done) begin
      sym_count <= '0;
    end else if (sym_valid && sym_ready) begin
      sym_count <= sym_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_bit_feeder.sv
// Directed bench for huffman_bit_feeder with a tiny comparator: "0"->0, "100"->+1, "111110011"->+7.
module tb_huffman_bit_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [8:0] shift_buf;
  logic [3:0] bit_count;
  logic       match_flag;
  logic [3:0] match_symbol, match_len;
  logic [3:0] sym_data;
  logic       sym_valid, sym_ready;
  logic       done, err;
  logic       kill;
`ifdef HUFF_SYM_COUNT_EN
  logic [15:0] sym_count;
`endif

  always #5 clk = ~clk;

  huffman_bit_feeder #(.MAX_CODE(9), .BUF_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .shift_buf(shift_buf), .bit_count(bit_count),
    .match_flag(match_flag), .match_symbol(match_symbol), .match_len(match_len),
    .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .done(done), .err(err)
`ifdef HUFF_SYM_COUNT_EN
    , .sym_count(sym_count)
`endif
  );

  // Comparator ignores bit_count on purpose, so padded windows still "match".
  always_comb begin
    match_flag   = 1'b0;
    match_symbol = 4'd0;
    match_len    = 4'd0;
    if (!shift_buf[8]) begin
      match_flag = 1'b1; match_symbol = 4'd0; match_len = 4'd1;
    end else if (shift_buf[8:6] == 3'b100) begin
      match_flag = 1'b1; match_symbol = 4'd1; match_len = 4'd3;
    end else if (shift_buf == 9'b111110011) begin
      match_flag = 1'b1; match_symbol = 4'd7; match_len = 4'd9;
    end
    if (kill) match_flag = 1'b0;
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_hs, last_hs, done_cyc, n_done;
  logic [3:0] got_q[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst && sym_valid && sym_ready) begin
      got_q.push_back(sym_data);
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    first_hs = -1;
    last_hs  = -1;
    done_cyc = -1;
    n_done   = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    sym_ready = 1'b0; kill = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_syms);
    int n = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_done_seen"}, done, 1);
`ifdef HUFF_SYM_COUNT_EN
    check({tag, "_sym_count"}, sym_count, exp_syms);
`endif
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
`ifdef HUFF_SYM_COUNT_EN
    check({tag, "_sym_count_clr"}, sym_count, 0);
`endif
    check({tag, "_n_done"}, n_done, 1);
    check({tag, "_count_zero"}, bit_count, 0);
    check({tag, "_syms_n"}, got_q.size(), exp_syms);
  endtask

  task automatic check_syms(input string tag, input logic [3:0] exp[$]);
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), got_q[i], exp[i]);
  endtask

  initial begin
    logic [3:0] e[$];
    logic stable_ok;
    int n;

    reset_dut();
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_data", sym_data, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_bit_count", bit_count, 0);
    check("rst_shift_buf", shift_buf, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // 0x00: eight 1-bit zero codes
    clear_mon(); sym_ready = 1'b1;
    send_byte(8'h00, 1'b1);
    wait_done("t1", 8);
    e.delete(); for (int i = 0; i < 8; i++) e.push_back(4'd0);
    check_syms("t1", e);
    check("t1_span", last_hs - first_hs, 7);
    check("t1_done_lat", done_cyc - last_hs, 1);
    check("t1_err", err, 0);

    // 0xF9 0x80: 9-bit +7 across the byte boundary, then seven zeros
    clear_mon();
    send_byte(8'hF9, 1'b0);
    send_byte(8'h80, 1'b1);
    wait_done("t2", 8);
    e.delete(); e.push_back(4'd7); for (int i = 0; i < 7; i++) e.push_back(4'd0);
    check_syms("t2", e);
    check("t2_done_lat", done_cyc - last_hs, 1);

    // 0x81: +1, four zeros, trailing 1 is padding
    clear_mon();
    send_byte(8'h81, 1'b1);
    wait_done("t3", 5);
    e.delete(); e.push_back(4'd1); for (int i = 0; i < 4; i++) e.push_back(4'd0);
    check_syms("t3", e);
    check("t3_err", err, 0);

    // 4 x 0x80 with a 5-cycle stall after the first symbol
    clear_mon(); sym_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send_byte(8'h80, (k == 3));
      end
      begin
        n = 0;
        while (!sym_valid && n < 50) begin
          @(posedge clk); #1; n++;
        end
        check("t4_first_valid", sym_valid, 1);
        stable_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
          if (!(sym_valid === 1'b1 && sym_data === 4'd1)) stable_ok = 1'b0;
          if (c < 4) begin @(posedge clk); #1; end
        end
        check("t4_stable", stable_ok, 1);
        check("t4_in_ready_low", in_ready, 0);
        check("t4_bit_count_sat", bit_count, 9);
        sym_ready = 1'b1;
      end
    join
    wait_done("t4", 24);
    e.delete();
    for (int b = 0; b < 4; b++) begin
      e.push_back(4'd1);
      for (int i = 0; i < 5; i++) e.push_back(4'd0);
    end
    check_syms("t4", e);

    // No match: two 0xFF bytes make the stream undecodable
    clear_mon(); kill = 1'b1;
    send_byte(8'hFF, 1'b0);
    check("t5_err_pre", err, 0);
    check("t5_count8", bit_count, 8);
    send_byte(8'hFF, 1'b0);
    @(posedge clk); #1;
    check("t5_err_set", err, 1);
    check("t5_buf_clr", shift_buf, 0);
    check("t5_count_clr", bit_count, 0);
    repeat (4) @(posedge clk); #1;
    check("t5_err_sticky", err, 1);
    check("t5_no_syms", got_q.size(), 0);
    check("t5_no_done", n_done, 0);
    reset_dut();
    check("t5_err_rst", err, 0);

    // Reset with a pending symbol, then a clean stream
    clear_mon();
    send_byte(8'h80, 1'b1);
    n = 0;
    while (!sym_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("t6_pending", sym_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_valid_clr", sym_valid, 0);
    check("t6_count_clr", bit_count, 0);
    check("t6_in_ready", in_ready, 1);
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t6_no_done", n_done, 0);
    check("t6_still_idle", sym_valid, 0);
    clear_mon(); sym_ready = 1'b1;
    send_byte(8'h00, 1'b1);
    wait_done("t6", 8);
    e.delete(); for (int i = 0; i < 8; i++) e.push_back(4'd0);
    check_syms("t6", e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
